// File: rtl/waveform_capture.sv
// Scrolling ECG trace writer: decimates samples into a circular buffer
// and replays it per display column with a frame-latched base.
module waveform_capture #(
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 9,
    parameter int DEC_LOG2 = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                freeze,
    input  logic                clear,
    input  logic                frame_start,
    input  logic [10:0]         hcount,
    output logic [SAMPLE_W-1:0] signal_out,
    output logic [ADDR_W-1:0]   wr_ptr,
    output logic                frozen,
    output logic                busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int ACC_W = SAMPLE_W + DEC_LOG2;
    localparam int CNT_W = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DEC_LOG2) - 1);
    localparam logic [ADDR_W-1:0] ADR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        FROZEN
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0]        clr_adr;
    logic [ADDR_W-1:0]        base;
    logic [ADDR_W-1:0]        rd_adr;
    logic [ADDR_W-1:0]        wr_adr;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]         dec_cnt;
    logic                     accept;
    logic                     dec_last;
    logic                     sample_write;
    logic                     ram_we;
    logic [SAMPLE_W-1:0]      avg;
    logic [SAMPLE_W-1:0]      wr_data;
    logic [SAMPLE_W-1:0]      rd_data;
    logic                     out_of_range;
    logic                     blank_q;
    logic [SAMPLE_W-1:0]      mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) state <= CLEAR;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            CLEAR: begin
                if (!clear && clr_adr == ADR_LAST)
                    state_next = freeze ? FROZEN : RUN;
            end
            RUN: begin
                if (clear)       state_next = CLEAR;
                else if (freeze) state_next = FROZEN;
            end
            FROZEN: begin
                if (clear)        state_next = CLEAR;
                else if (!freeze) state_next = RUN;
            end
            default: state_next = CLEAR;
        endcase
    end

    assign accept       = (state == RUN) && sample_valid;
    assign dec_last     = (dec_cnt == CNT_LAST);
    assign sample_write = accept && dec_last;
    assign sum          = acc + ACC_W'($signed(sample_in));
    assign avg          = SAMPLE_W'(sum >>> DEC_LOG2);

    assign ram_we  = !reset && ((state == CLEAR) || sample_write);
    assign wr_adr  = (state == CLEAR) ? clr_adr : wr_ptr;
    assign wr_data = (state == CLEAR) ? '0 : avg;

    assign rd_adr       = base + hcount[ADDR_W-1:0];
    assign out_of_range = 32'(hcount) >= 32'(DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_adr <= '0;
            wr_ptr  <= '0;
            acc     <= '0;
            dec_cnt <= '0;
            base    <= '0;
        end else begin
            if (frame_start)
                base <= wr_ptr;

            if (state == CLEAR)
                clr_adr <= clear ? '0 : clr_adr + 1'b1;
            else if (state_next == CLEAR)
                clr_adr <= '0;

            // A write due in the cycle clear arrives still lands at the old pointer
            if (sample_write)
                wr_ptr <= wr_ptr + 1'b1;
            if (state != CLEAR && clear)
                wr_ptr <= '0;

            if (state != RUN || state_next != RUN) begin
                acc     <= '0;
                dec_cnt <= '0;
            end else if (accept) begin
                if (dec_last) begin
                    acc     <= '0;
                    dec_cnt <= '0;
                end else begin
                    acc     <= sum;
                    dec_cnt <= dec_cnt + 1'b1;
                end
            end
        end
    end

    // Read-first simple dual-port RAM, contents not reset
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[wr_adr] <= wr_data;
        rd_data <= mem[rd_adr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q    <= 1'b1;
            signal_out <= '0;
        end else begin
            blank_q    <= out_of_range || (state == CLEAR);
            signal_out <= (blank_q || state == CLEAR) ? '0 : rd_data;
        end
    end

    assign frozen = (state == FROZEN);
    assign busy   = (state == CLEAR);

endmodule

// File: tb/tb_waveform_capture.sv
// Randomized bench for waveform_capture against a queue-based
// averaging model of the trace buffer.
module tb_waveform_capture;

    localparam int AW    = 10;
    localparam int SW    = 9;
    localparam int DEPTH = 1024;
    localparam int DN    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] sample_in;
    logic          sample_valid;
    logic          freeze;
    logic          clear;
    logic          frame_start;
    logic [10:0]   hcount;
    logic [SW-1:0] signal_out;
    logic [AW-1:0] wr_ptr;
    logic          frozen;
    logic          busy;

    waveform_capture #(
        .ADDR_W  (AW),
        .SAMPLE_W(SW),
        .DEC_LOG2(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .freeze      (freeze),
        .clear       (clear),
        .frame_start (frame_start),
        .hcount      (hcount),
        .signal_out  (signal_out),
        .wr_ptr      (wr_ptr),
        .frozen      (frozen),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: 0 = clearing, 1 = running, 2 = frozen
    int mem_m [DEPTH];
    int wr_m;
    int base_m;
    int mode_m;
    int left_m;
    int pend [$];

    function automatic int floor_div(input int s, input int d);
        int q;
        q = s / d;
        if ((s % d) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    task automatic enter_clear();
        mode_m = 0;
        left_m = DEPTH;
        wr_m   = 0;
        pend.delete();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
    endtask

    task automatic step();
        int s;
        if (reset) begin
            enter_clear();
            base_m = 0;
        end else begin
            if (frame_start) base_m = wr_m;
            case (mode_m)
                0: begin
                    if (clear) left_m = DEPTH;
                    else begin
                        left_m--;
                        if (left_m == 0) mode_m = freeze ? 2 : 1;
                    end
                end
                1: begin
                    if (sample_valid) begin
                        pend.push_back(int'($signed(sample_in)));
                        if (pend.size() == DN) begin
                            s = 0;
                            foreach (pend[i]) s += pend[i];
                            mem_m[wr_m] = floor_div(s, DN);
                            wr_m = (wr_m + 1) % DEPTH;
                            pend.delete();
                        end
                    end
                    if (clear) enter_clear();
                    else if (freeze) begin
                        mode_m = 2;
                        pend.delete();
                    end
                end
                default: begin
                    if (clear) enter_clear();
                    else if (!freeze) mode_m = 1;
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        sample_in    = SW'(v);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic sweep(input string name, input int last);
        int expv [];
        int shown;
        int got;
        shown = 0;
        expv = new[last + 1];
        for (int k = 0; k <= last + 1; k++) begin
            if (k <= last) begin
                hcount = 11'(k);
                if (mode_m == 0 || k >= DEPTH) expv[k] = 0;
                else expv[k] = mem_m[(base_m + k) % DEPTH];
            end
            step();
            if (k >= 1) begin
                got = int'($signed(signal_out));
                checks++;
                if (got !== expv[k-1]) begin
                    errors++;
                    if (shown < 8)
                        $display("FAIL %s col %0d got %0d expected %0d",
                                 name, k - 1, got, expv[k-1]);
                    shown++;
                end
            end
        end
        hcount = '0;
    endtask

    task automatic read_col(input int col, output int v);
        hcount = 11'(col);
        step();
        step();
        v = int'($signed(signal_out));
        hcount = '0;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b1 || frozen !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b frozen=%b expected 1 0", busy, frozen);
        end
        checks++;
        if (wr_ptr !== '0 || signal_out !== '0) begin
            errors++;
            $display("FAIL reset_regs wr_ptr=%0d out=%0d expected 0 0", wr_ptr, signal_out);
        end
        reset = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (busy && n < 3000);
        checks++;
        if (n != 1024) begin
            errors++;
            $display("FAIL reset_busy_len got %0d cycles expected 1024", n);
        end
        checks++;
        if (frozen !== 1'b0) begin
            errors++;
            $display("FAIL reset_exit frozen=%b expected 0", frozen);
        end
        sweep("reset_zero", DEPTH - 1);
    endtask

    task automatic test_decimate();
        int v;
        send(4);
        send(8);
        send(-4);
        send(-9);
        checks++;
        if (wr_ptr !== AW'(1)) begin
            errors++;
            $display("FAIL dec_wr_ptr got %0d expected 1", wr_ptr);
        end
        pulse_frame();
        read_col(1023, v);
        checks++;
        if (v != -1) begin
            errors++;
            $display("FAIL dec_value got %0d expected -1", v);
        end
    endtask

    task automatic test_wrap();
        for (int e = 0; e < 1025 * DN; e++) begin
            if ($urandom_range(0, 2) == 0) step();
            send(int'($urandom_range(0, 511)) - 256);
        end
        checks++;
        if (int'(wr_ptr) != wr_m) begin
            errors++;
            $display("FAIL wrap_ptr got %0d expected %0d", wr_ptr, wr_m);
        end
        pulse_frame();
        sweep("wrap", DEPTH - 1);
    endtask

    task automatic test_freeze();
        int p0;
        int v;
        repeat (3) send(int'($urandom_range(0, 100)));
        freeze = 1'b1;
        step();
        checks++;
        if (frozen !== 1'b1) begin
            errors++;
            $display("FAIL frz_enter frozen=%b expected 1", frozen);
        end
        p0 = wr_m;
        repeat (8) send(int'($urandom_range(0, 100)));
        checks++;
        if (frozen !== 1'b1 || int'(wr_ptr) != p0) begin
            errors++;
            $display("FAIL frz_hold frozen=%b wr_ptr=%0d expected 1 %0d", frozen, wr_ptr, p0);
        end
        freeze = 1'b0;
        step();
        checks++;
        if (frozen !== 1'b0) begin
            errors++;
            $display("FAIL frz_exit frozen=%b expected 0", frozen);
        end
        repeat (4) send(20);
        checks++;
        if (int'(wr_ptr) != (p0 + 1) % DEPTH) begin
            errors++;
            $display("FAIL frz_one_entry wr_ptr=%0d expected %0d", wr_ptr, (p0 + 1) % DEPTH);
        end
        pulse_frame();
        read_col(1023, v);
        checks++;
        if (v != 20) begin
            errors++;
            $display("FAIL frz_value got %0d expected 20", v);
        end
        // Sample arriving with freeze still completes its entry
        repeat (3) send(-30);
        freeze = 1'b1;
        send(-31);
        freeze = 1'b0;
        step();
        pulse_frame();
        read_col(1023, v);
        checks++;
        if (v != -31) begin
            errors++;
            $display("FAIL frz_same_cycle got %0d expected -31", v);
        end
    endtask

    task automatic test_frame_hold();
        int keep;
        int v;
        pulse_frame();
        sweep("hold_pre", DEPTH - 1);
        keep = mem_m[(base_m + 1023) % DEPTH];
        repeat (50 * DN) send(int'($urandom_range(0, 511)) - 256);
        sweep("hold_mid", DEPTH - 1);
        read_col(1023, v);
        checks++;
        if (v != keep) begin
            errors++;
            $display("FAIL hold_col1023 got %0d expected %0d", v, keep);
        end
        pulse_frame();
        sweep("hold_next", DEPTH - 1);
    endtask

    task automatic test_ramp_clear();
        int n;
        sweep("ramp", 1100);
        hcount = 11'd300;
        clear  = 1'b1;
        step();
        clear = 1'b0;
        n = 0;
        while (busy && n < 3000) begin
            if (n == 500) begin
                checks++;
                if (signal_out !== '0) begin
                    errors++;
                    $display("FAIL clr_out got %0d expected 0", signal_out);
                end
            end
            step();
            n++;
        end
        checks++;
        if (n != 1024) begin
            errors++;
            $display("FAIL clr_busy_len got %0d expected 1024", n);
        end
        checks++;
        if (wr_ptr !== '0) begin
            errors++;
            $display("FAIL clr_wr_ptr got %0d expected 0", wr_ptr);
        end
        pulse_frame();
        sweep("clr_zero", DEPTH - 1);
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) freeze = ~freeze;
            sample_in    = SW'($urandom_range(0, 511));
            sample_valid = ($urandom_range(0, 1) == 1);
            step();
            checks++;
            if (frozen !== (mode_m == 2) || int'(wr_ptr) != wr_m) begin
                errors++;
                $display("FAIL rnd_state cyc %0d frozen=%b wr_ptr=%0d expected %0d %0d",
                         c, frozen, wr_ptr, mode_m == 2, wr_m);
            end
        end
        sample_valid = 1'b0;
        freeze = 1'b0;
        step();
        pulse_frame();
        sweep("rnd", DEPTH - 1);
    endtask

    initial begin
        reset        = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        freeze       = 1'b0;
        clear        = 1'b0;
        frame_start  = 1'b0;
        hcount       = '0;
        wr_m         = 0;
        base_m       = 0;
        mode_m       = 0;
        left_m       = DEPTH;
        test_reset();
        test_decimate();
        test_wrap();
        test_freeze();
        test_frame_hold();
        test_ramp_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
